// File: rtl/pulse_burst_scheduler_pkg.sv
// ---------------------------------------------------------------------------------------------------
// pulse_sched_pkg
//   Shared definitions for the pulse burst scheduler: FSM state encoding, default parameter values
//   and a counter-width helper.
//   Used by: pulse_burst_scheduler (top), ms_tick_gen (prescaler).
// ---------------------------------------------------------------------------------------------------
package pulse_sched_pkg;

   // Scheduler FSM encoding; the numeric values are fixed so they can be read back by firmware.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int unsigned MS_TICKS_DEF = 50000;  // sys_clk cycles per ms at 50 MHz
   localparam int unsigned BURST_W_DEF  = 10;
   localparam int unsigned CYCLE_W_DEF  = 14;

   // Width needed to count 0..n-1; never below 1 so a 1-tick prescaler still has a register.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pulse_burst_scheduler_ms_tick_gen.sv
// ---------------------------------------------------------------------------------------------------
// ms_tick_gen
//   Millisecond prescaler. Counts 0..MS_TICKS-1 and flags the last count of each millisecond.
//   A synchronous restart forces the count back to 0 so the next millisecond is aligned to it.
// Ports
//   sys_clk    in   1   system clock
//   rst        in   1   asynchronous reset, active-high
//   i_restart  in   1   synchronous restart (count -> 0 at the next edge)
//   o_tick     out  1   high during the last sys_clk cycle of each millisecond
// ---------------------------------------------------------------------------------------------------
module ms_tick_gen
   import pulse_sched_pkg::*;
#(
   parameter int unsigned MS_TICKS = MS_TICKS_DEF
) (
   input  logic sys_clk,
   input  logic rst,
   input  logic i_restart,
   output logic o_tick
);

   localparam int unsigned    PRE_W = cnt_width(MS_TICKS);
   localparam logic [PRE_W-1:0] LAST = PRE_W'(MS_TICKS - 1);

   logic [PRE_W-1:0] r_cnt;
   logic [PRE_W-1:0] w_cnt_d;
   logic             w_last;

   assign w_last = (r_cnt == LAST);

   always_comb begin
      w_cnt_d = r_cnt + 1'b1;
      if (i_restart || w_last) begin
         w_cnt_d = '0;
      end
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_cnt_d;
      end
   end

   // Not gated by i_restart: the top derives its restart from this tick.
   assign o_tick = w_last;

endmodule

// File: rtl/pulse_burst_scheduler.sv
// ---------------------------------------------------------------------------------------------------
// pulse_burst_scheduler
//   Sequences the DDS pulse generators into a train of bursts. A start command launches N bursts,
//   one every cycle_ms milliseconds; each burst is a one-cycle dds_trig_o. The first trigger follows
//   the start edge directly, later ones come exactly cycle_ms*MS_TICKS cycles apart, and the train
//   completes one full period after the last trigger.
//
//   Optional feature macro: PULSE_SCHED_CONTINUOUS_EN
//     defined   - bursts_num_i == 0 starts a continuous train that runs until stop_i.
//     undefined - bursts_num_i == 0 is rejected with cfg_err_o.
//
// Ports
//   sys_clk       in   1        system clock
//   rst           in   1        asynchronous reset, active-high
//   start_i       in   1        1-cycle start command
//   stop_i        in   1        1-cycle stop command
//   bursts_num_i  in   BURST_W  bursts per train (sampled at start)
//   cycle_ms_i    in   CYCLE_W  burst period in ms (sampled at start)
//   dds_busy_i    in   1        DDS still emitting the previous burst
//   dds_trig_o    out  1        1-cycle burst trigger
//   busy_o        out  1        train in progress
//   burst_idx_o   out  BURST_W  bursts issued in the current train (saturating)
//   done_o        out  1        1-cycle pulse: train completed
//   abort_o       out  1        1-cycle pulse: train stopped
//   cfg_err_o     out  1        1-cycle pulse: start rejected
//   overrun_o     out  1        sticky: trigger issued while dds_busy_i was high
// ---------------------------------------------------------------------------------------------------
module pulse_burst_scheduler
   import pulse_sched_pkg::*;
#(
   parameter int unsigned MS_TICKS = MS_TICKS_DEF,
   parameter int unsigned BURST_W  = BURST_W_DEF,
   parameter int unsigned CYCLE_W  = CYCLE_W_DEF
) (
   input  logic               sys_clk,
   input  logic               rst,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic [BURST_W-1:0] bursts_num_i,
   input  logic [CYCLE_W-1:0] cycle_ms_i,
   input  logic               dds_busy_i,
   output logic               dds_trig_o,
   output logic               busy_o,
   output logic [BURST_W-1:0] burst_idx_o,
   output logic               done_o,
   output logic               abort_o,
   output logic               cfg_err_o,
   output logic               overrun_o
);

   localparam logic [BURST_W-1:0] IDX_MAX = '1;

   state_e             r_state, w_state_d;
   logic [BURST_W-1:0] r_count, w_count_d;  // shadow burst count
   logic [CYCLE_W-1:0] r_cycle, w_cycle_d;  // shadow period in ms
   logic [BURST_W-1:0] r_idx,   w_idx_d;
   logic [CYCLE_W-1:0] r_ms,    w_ms_d;
   logic               r_trig,    w_trig_d;
   logic               r_busy,    w_busy_d;
   logic               r_done,    w_done_d;
   logic               r_abort,   w_abort_d;
   logic               r_cfg_err, w_cfg_err_d;
   logic               r_overrun, w_overrun_d;

   logic w_tick;
   logic w_restart;
   logic w_cfg_bad;
   logic w_cont;
   logic w_expire;
   logic w_more;
   logic w_fire;

`ifdef PULSE_SCHED_CONTINUOUS_EN
   assign w_cfg_bad = (cycle_ms_i == '0);
   assign w_cont    = (r_count == '0);
`else
   assign w_cfg_bad = (cycle_ms_i == '0) || (bursts_num_i == '0);
   assign w_cont    = 1'b0;
`endif

   // Period ends on the last prescaler cycle of the last ms of the period.
   assign w_expire = (r_state == RUN) && w_tick && (r_ms == (r_cycle - 1'b1));
   assign w_more   = w_cont || (r_idx < r_count);
   // stop_i wins over a coinciding period expiry.
   assign w_fire   = w_expire && w_more && !stop_i;
   // Outside RUN both counters are held at 0, so the start edge and each trigger edge align them.
   assign w_restart = (r_state != RUN) || w_fire;

   ms_tick_gen #(
      .MS_TICKS (MS_TICKS)
   ) u_ms_tick_gen (
      .sys_clk   (sys_clk),
      .rst       (rst),
      .i_restart (w_restart),
      .o_tick    (w_tick)
   );

   // ms counter: 0..r_cycle-1 within one period.
   always_comb begin
      w_ms_d = r_ms;
      if (w_restart) begin
         w_ms_d = '0;
      end else if (w_tick) begin
         w_ms_d = r_ms + 1'b1;
      end
   end

   // Next state and next registered outputs.
   always_comb begin
      w_state_d   = r_state;
      w_count_d   = r_count;
      w_cycle_d   = r_cycle;
      w_idx_d     = r_idx;
      w_trig_d    = 1'b0;
      w_busy_d    = 1'b0;
      w_done_d    = 1'b0;
      w_abort_d   = 1'b0;
      w_cfg_err_d = 1'b0;
      // Overrun looks at dds_busy_i during the cycle the trigger is actually driven.
      w_overrun_d = r_overrun | (r_trig & dds_busy_i);

      unique case (r_state)
         IDLE: begin
            if (start_i) begin
               if (w_cfg_bad) begin
                  w_cfg_err_d = 1'b1;
               end else begin
                  w_state_d   = RUN;
                  w_count_d   = bursts_num_i;
                  w_cycle_d   = cycle_ms_i;
                  w_idx_d     = BURST_W'(1);
                  w_trig_d    = 1'b1;
                  w_busy_d    = 1'b1;
                  w_overrun_d = 1'b0;
               end
            end
         end
         RUN: begin
            if (stop_i) begin
               w_state_d = IDLE;
               w_abort_d = 1'b1;
            end else if (w_expire) begin
               if (w_more) begin
                  w_trig_d = 1'b1;
                  w_busy_d = 1'b1;
                  w_idx_d  = (r_idx == IDX_MAX) ? r_idx : r_idx + 1'b1;
               end else begin
                  w_state_d = DONE;
                  w_done_d  = 1'b1;
               end
            end else begin
               w_busy_d = 1'b1;
            end
         end
         DONE: begin
            w_state_d = IDLE;
         end
         default: begin
            w_state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge sys_clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_count   <= '0;
         r_cycle   <= '0;
         r_idx     <= '0;
         r_ms      <= '0;
         r_trig    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_abort   <= 1'b0;
         r_cfg_err <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_count   <= w_count_d;
         r_cycle   <= w_cycle_d;
         r_idx     <= w_idx_d;
         r_ms      <= w_ms_d;
         r_trig    <= w_trig_d;
         r_busy    <= w_busy_d;
         r_done    <= w_done_d;
         r_abort   <= w_abort_d;
         r_cfg_err <= w_cfg_err_d;
         r_overrun <= w_overrun_d;
      end
   end

   assign dds_trig_o  = r_trig;
   assign busy_o      = r_busy;
   assign burst_idx_o = r_idx;
   assign done_o      = r_done;
   assign abort_o     = r_abort;
   assign cfg_err_o   = r_cfg_err;
   assign overrun_o   = r_overrun;

endmodule
